pio_cfg_seq: RTL and testbench
==============================

Name: pio_cfg_seq

Overview:
- Sequencer that configures one PIO state machine through the PIO action port, then feeds it TX data.
- Streams instructions from a synchronous program ROM and issues the fixed configuration writes: wrap/exec control, clock divider, pin groups, shift control, enable.
- Once running, forwards a valid/ready sample stream as PUSH actions, gated by the PIO tx_full flag.
- Sits between the PIO core and a source such as an I2S sample FIFO, replacing hand-sequenced configuration writes.

Parameters:
- PROG_DEPTH, 32, program ROM depth and maximum program length in instructions
- SM_BITS, 2, width of the state-machine index

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse that begins configuration; ignored unless state is IDLE
- stop  in  1  one-cycle pulse that disables the machine; honoured only in RUN
- sm_sel  in  SM_BITS  target state machine; captured on start
- plen  in  6  program length, 0..32; captured on start
- cfg_exec  in  32  exec control word (wrap); captured on start
- cfg_div  in  24  clock divider; captured on start, zero-extended to 32 bits on din
- cfg_grps  in  32  pin group word; captured on start
- cfg_shift  in  32  shift control word; captured on start
- prog_addr  out  5  ROM address
- prog_data  in  16  ROM data, valid one cycle after prog_addr
- s_valid  in  1  sample valid
- s_data  in  32  sample word
- s_ready  out  1  sample accepted this cycle
- tx_full  in  4  PIO per-machine TX FIFO full flags
- action  out  4  PIO action code
- index  out  5  instruction index for INSTR
- mindex  out  SM_BITS  machine index
- din  out  32  PIO data
- busy  out  1  high in every state except IDLE
- running  out  1  high in RUN

Behaviour:
- Reset values: action=NONE, din=0, index=0, mindex=0, prog_addr=0, s_ready=0, busy=0, running=0. All outputs are registered.
- Protocol: one action per cycle. Any cycle with no command drives action=NONE and din=0.
- States: IDLE -> LOAD -> PEND -> DIV -> GRPS -> SHIFT -> EN -> RUN -> DIS -> IDLE.
- IDLE -> LOAD: on start, capture sm_sel, plen (saturated to 32) and the four config words.
  - If plen=0, go directly to PEND.
- LOAD (ROM pipelined):
  - Cycle k (0..plen-1) drives prog_addr=k.
  - Cycle k+1 drives action=INSTR, index=k, din={16'b0, prog_data}.
  - LOAD therefore lasts plen+1 cycles; the last INSTR is issued in the same cycle the FSM advances to PEND.
- PEND, DIV, GRPS, SHIFT, EN: each is exactly one cycle and emits one action.
  - PEND: action=PEND, din=cfg_exec.
  - DIV: action=DIV, din=cfg_div.
  - GRPS: action=GRPS, din=cfg_grps.
  - SHIFT: action=SHIFT, din=cfg_shift.
  - EN: action=EN, din=1.
- mindex equals the captured sm_sel from start until return to IDLE.
- RUN:
  - s_ready = s_valid & ~tx_full[sm] & ~push_d, where push_d is 1 in the cycle after a PUSH.
  - This leaves one guard cycle so that tx_full reflects the previous push.
  - On s_ready, the next cycle drives action=PUSH, din=s_data. Sustained throughput is one push per two cycles.
  - tx_full indexing uses the low bits of sm; bits beyond 4 are ignored.
- Stop:
  - stop in RUN -> DIS. s_ready is forced to 0 from the stop cycle.
  - A PUSH already registered for the stop cycle still completes.
  - DIS emits action=EN, din=0 for one cycle, then returns to IDLE.
  - stop outside RUN is ignored.
- Simultaneous events:
  - start while busy is ignored.
  - stop and s_valid in the same RUN cycle: stop wins and no sample is accepted.
- Reset mid-operation: returns to IDLE within one cycle, with action=NONE the cycle after reset is sampled. No partial config word is re-issued.

Decomposition:
- Shared package pio_pkg:
  - action code constants NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, IMM=9, SHIFT=10
  - FSM state enum
- No sub-module; the ROM is external to this block.

Test Plan:
- Config sequence: plen=10, div=24'h0100, grps=32'h40100400, exec=32'h00009000, shift=0, sm=0, start.
  - Required: INSTR idx 0..9 with ROM data in order, then PEND 00009000, DIV 00000100, GRPS 40100400, SHIFT 0, EN 1 on consecutive cycles.
  - running asserted 17 cycles after the start cycle: 11 LOAD cycles, 5 config cycles, then entry to RUN.
- plen=0: start -> first action is PEND one cycle later; no INSTR emitted.
- Stream: s_valid held with s_data=ffff0000 then 0000ffff, tx_full=0.
  - Required: PUSH every second cycle carrying those values in order; s_ready alternates 1/0.
- Backpressure: tx_full[0]=1 for 8 cycles while s_valid=1.
  - Required: no PUSH and s_ready=0; the first PUSH occurs one cycle after tx_full drops and the sample is not lost.
- Stop with pending sample: stop with s_valid=1 -> s_ready=0, one EN with din=0, then IDLE with busy=0.
  - A second start is accepted afterwards, and sm_sel=2 drives mindex=2.
- Reset during LOAD at instruction 4: action=NONE next cycle, busy=0; start afterwards reloads from index 0.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg: shared PIO action codes and the configuration sequencer states.
// Imported by pio_cfg_seq and its testbench.
package pio_pkg;

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SIDES = 4'd8;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PEND,
        ST_DIV,
        ST_GRPS,
        ST_SHIFT,
        ST_EN,
        ST_RUN,
        ST_DIS
    } seq_state_t;

endpackage

// File: rtl/pio_cfg_seq.sv
// pio_cfg_seq: loads a PIO program from an external sync ROM, issues the
// config writes, enables the machine, then streams samples as PUSH actions.
// Ports: clk/reset (sync, active-high); start/stop control pulses;
//   sm_sel/plen/cfg_* captured on start; prog_addr/prog_data ROM port;
//   s_valid/s_data/s_ready sample stream; tx_full PIO FIFO flags;
//   action/index/mindex/din PIO action port; busy/running status.
module pio_cfg_seq
    import pio_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int SM_BITS    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [SM_BITS-1:0] sm_sel,
    input  logic [5:0]         plen,
    input  logic [31:0]        cfg_exec,
    input  logic [23:0]        cfg_div,
    input  logic [31:0]        cfg_grps,
    input  logic [31:0]        cfg_shift,
    output logic [4:0]         prog_addr,
    input  logic [15:0]        prog_data,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    output logic               s_ready,
    input  logic [3:0]         tx_full,
    output logic [3:0]         action,
    output logic [4:0]         index,
    output logic [SM_BITS-1:0] mindex,
    output logic [31:0]        din,
    output logic               busy,
    output logic               running
);

    localparam logic [5:0] PLEN_MAX = 6'(PROG_DEPTH);

    seq_state_t         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d, cnt_inc;
    logic [5:0]         len_q, plen_sat;
    logic [SM_BITS-1:0] sm_q;
    logic [31:0]        exec_q, grps_q, shift_q;
    logic [23:0]        div_q;
    logic               push_q;
    logic [1:0]         fidx;
    logic [3:0]         act_d;
    logic [31:0]        din_d;
    logic [4:0]         idx_d, addr_d;

    assign cnt_inc  = cnt_q + 6'd1;
    assign plen_sat = (plen > PLEN_MAX) ? PLEN_MAX : plen;
    assign mindex   = sm_q;

    // Only four machines have a tx_full flag; upper index bits are ignored.
    if (SM_BITS >= 2) begin : g_fidx
        assign fidx = sm_q[1:0];
    end else begin : g_fidx1
        assign fidx = {1'b0, sm_q[0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = ACT_NONE;
        din_d   = '0;
        idx_d   = '0;
        addr_d  = '0;
        s_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = (plen_sat == 6'd0) ? ST_PEND : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // ROM data trails its address by one cycle, so the INSTR
                // for address k is built in LOAD cycle k+1.
                if (cnt_q != 6'd0) begin
                    act_d = ACT_INSTR;
                    idx_d = cnt_q[4:0] - 5'd1;
                    din_d = {16'h0, prog_data};
                end
                if (cnt_q == len_q) begin
                    state_d = ST_PEND;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc < len_q) addr_d = cnt_inc[4:0];
                end
            end
            ST_PEND: begin
                act_d   = ACT_PEND;
                din_d   = exec_q;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                act_d   = ACT_DIV;
                din_d   = {8'h0, div_q};
                state_d = ST_GRPS;
            end
            ST_GRPS: begin
                act_d   = ACT_GRPS;
                din_d   = grps_q;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                act_d   = ACT_SHIFT;
                din_d   = shift_q;
                state_d = ST_EN;
            end
            ST_EN: begin
                act_d   = ACT_EN;
                din_d   = 32'd1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DIS;
                end else begin
                    // push_q blocks the cycle after a PUSH so tx_full
                    // has caught up before the next sample is taken.
                    s_ready = s_valid & ~tx_full[fidx] & ~push_q;
                    if (s_ready) begin
                        act_d = ACT_PUSH;
                        din_d = s_data;
                    end
                end
            end
            ST_DIS: begin
                act_d   = ACT_EN;
                din_d   = 32'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            sm_q      <= '0;
            exec_q    <= '0;
            div_q     <= '0;
            grps_q    <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            action    <= ACT_NONE;
            din       <= '0;
            index     <= '0;
            prog_addr <= '0;
            busy      <= 1'b0;
            running   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            push_q    <= s_ready;
            action    <= act_d;
            din       <= din_d;
            index     <= idx_d;
            prog_addr <= addr_d;
            busy      <= (state_d != ST_IDLE);
            running   <= (state_d == ST_RUN);
            if (state_q == ST_IDLE && start) begin
                len_q   <= plen_sat;
                sm_q    <= sm_sel;
                exec_q  <= cfg_exec;
                div_q   <= cfg_div;
                grps_q  <= cfg_grps;
                shift_q <= cfg_shift;
            end
        end
    end

endmodule

// File: tb/tb_pio_cfg_seq.sv
// tb_pio_cfg_seq: directed bench for pio_cfg_seq with a timeline model
// compared against the DUT every cycle plus literal expectations.
module tb_pio_cfg_seq;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  sm_sel = '0;
    logic [5:0]  plen = '0;
    logic [31:0] cfg_exec = '0;
    logic [23:0] cfg_div = '0;
    logic [31:0] cfg_grps = '0;
    logic [31:0] cfg_shift = '0;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [3:0]  tx_full = '0;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic        busy;
    logic        running;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit last_rdy = 0;
    logic [35:0] act_log[$];
    int acc_cyc[$];

    localparam int M_IDLE = 0;
    localparam int M_CFG  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DIS  = 3;

    int          m_mode = M_IDLE;
    int          m_t0 = 0;
    int          m_plen = 0;
    logic [1:0]  m_sm = '0;
    logic [31:0] m_exec = '0, m_grps = '0, m_shift = '0;
    logic [23:0] m_div = '0;
    logic [3:0]  na = ACT_NONE;
    logic [31:0] nd = '0;

    always #5 clk = ~clk;

    pio_cfg_seq #(.PROG_DEPTH(32), .SM_BITS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sm_sel(sm_sel), .plen(plen), .cfg_exec(cfg_exec),
        .cfg_div(cfg_div), .cfg_grps(cfg_grps), .cfg_shift(cfg_shift),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .tx_full(tx_full), .action(action), .index(index),
        .mindex(mindex), .din(din), .busy(busy), .running(running)
    );

    function automatic logic [15:0] rom_word(input logic [4:0] a);
        return {8'hA5, 3'b000, a};
    endfunction

    always @(posedge clk) prog_data <= rom_word(prog_addr);

    task automatic chk(input string nm, input logic [35:0] got,
                       input logic [35:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, got, exp, cyc);
    endtask

    function automatic logic [35:0] logq(input int i);
        if (i < act_log.size()) return act_log[i];
        return 36'hx;
    endfunction

    // Model: config timing from plen arithmetic, RUN from the
    // ready rule; expected values for cycle c, then advance on inputs.
    always @(negedge clk) begin : model
        logic [3:0]  ea;
        logic [31:0] ed;
        logic        er, eb, erun;
        int          d, nl, pt;
        ea = ACT_NONE; ed = '0; er = 1'b0; eb = 1'b0; erun = 1'b0;
        d  = cyc - m_t0;
        nl = (m_plen == 0) ? 0 : m_plen + 1;
        pt = 2 + nl;
        case (m_mode)
            M_CFG: begin
                eb = 1'b1;
                if (d >= pt - m_plen && d < pt) begin
                    ea = ACT_INSTR;
                    ed = {16'h0, rom_word(5'(d - pt + m_plen))};
                    if (chk_en)
                        chk("index", 36'(index), 36'(d - pt + m_plen));
                end else if (d == pt) begin
                    ea = ACT_PEND;  ed = m_exec;
                end else if (d == pt + 1) begin
                    ea = ACT_DIV;   ed = {8'h0, m_div};
                end else if (d == pt + 2) begin
                    ea = ACT_GRPS;  ed = m_grps;
                end else if (d == pt + 3) begin
                    ea = ACT_SHIFT; ed = m_shift;
                end
                if (chk_en && d >= 1 && d <= m_plen)
                    chk("prog_addr", 36'(prog_addr), 36'(d - 1));
            end
            M_RUN: begin
                eb = 1'b1; erun = 1'b1; ea = na; ed = nd;
                er = s_valid && !tx_full[m_sm] && !stop
                     && (na != ACT_PUSH);
            end
            M_DIS: begin
                eb = 1'b1; ea = na; ed = nd;
            end
            default: begin
                ea = na; ed = nd;
            end
        endcase
        if (chk_en) begin
            chk("action", 36'(action), 36'(ea));
            chk("din", 36'(din), 36'(ed));
            chk("busy", 36'(busy), 36'(eb));
            chk("running", 36'(running), 36'(erun));
            chk("s_ready", 36'(s_ready), 36'(er));
            chk("mindex", 36'(mindex), 36'(m_sm));
        end
        last_rdy = s_ready;
        if (action !== ACT_NONE) act_log.push_back({action, din});
        if (s_ready === 1'b1) acc_cyc.push_back(cyc);
        if (reset) begin
            m_mode = M_IDLE; na = ACT_NONE; nd = '0; m_sm = '0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    na = ACT_NONE; nd = '0;
                    if (start) begin
                        m_mode  = M_CFG;
                        m_t0    = cyc;
                        m_plen  = (plen > 6'd32) ? 32 : int'(plen);
                        m_sm    = sm_sel;
                        m_exec  = cfg_exec;
                        m_div   = cfg_div;
                        m_grps  = cfg_grps;
                        m_shift = cfg_shift;
                    end
                end
                M_CFG: begin
                    if (d + 1 == pt + 4) begin
                        m_mode = M_RUN; na = ACT_EN; nd = 32'd1;
                    end
                end
                M_RUN: begin
                    if (stop) begin
                        m_mode = M_DIS; na = ACT_NONE; nd = '0;
                    end else if (er) begin
                        na = ACT_PUSH; nd = s_data;
                    end else begin
                        na = ACT_NONE; nd = '0;
                    end
                end
                default: begin
                    m_mode = M_IDLE; na = ACT_EN; nd = '0;
                end
            endcase
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sm, input logic [5:0] pl,
                            input logic [31:0] ex, input logic [23:0] dv,
                            input logic [31:0] gr, input logic [31:0] sh,
                            output int t);
        sm_sel = sm; plen = pl; cfg_exec = ex;
        cfg_div = dv; cfg_grps = gr; cfg_shift = sh;
        start = 1'b1;
        t = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_run(input int lim);
        int n;
        n = 0;
        while (running !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk("run_timeout", 36'(running), 36'(1));
    endtask

    task automatic send(input logic [31:0] d, input int lim);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            ok = last_rdy;
        end
        s_valid = 1'b0;
        chk("send_timeout", 36'(ok), 36'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int t0;
        int lag;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        chk("rst_action", 36'(action), 36'(ACT_NONE));
        chk("rst_din", 36'(din), 36'(0));
        chk("rst_index", 36'(index), 36'(0));
        chk("rst_paddr", 36'(prog_addr), 36'(0));
        chk("rst_ready", 36'(s_ready), 36'(0));
        chk("rst_busy", 36'(busy), 36'(0));
        chk("rst_run", 36'(running), 36'(0));
        chk("rst_mindex", 36'(mindex), 36'(0));

        // Full configuration, plen=10
        act_log.delete();
        do_start(2'd0, 6'd10, 32'h00009000, 24'h000100,
                 32'h40100400, 32'h0, t0);
        wait_run(40);
        chk("run_lat", 36'(cyc - t0), 36'(17));
        step();
        chk("cfg_cnt", 36'(act_log.size()), 36'(15));
        chk("cfg_i0", logq(0), {ACT_INSTR, 32'h0000A500});
        chk("cfg_i9", logq(9), {ACT_INSTR, 32'h0000A509});
        chk("cfg_pend", logq(10), {ACT_PEND, 32'h00009000});
        chk("cfg_div", logq(11), {ACT_DIV, 32'h00000100});
        chk("cfg_grps", logq(12), {ACT_GRPS, 32'h40100400});
        chk("cfg_shift", logq(13), {ACT_SHIFT, 32'h0});
        chk("cfg_en", logq(14), {ACT_EN, 32'h1});

        // Stream at full rate
        act_log.delete();
        acc_cyc.delete();
        send(32'hffff0000, 4);
        send(32'h0000ffff, 4);
        step();
        chk("str_cnt", 36'(act_log.size()), 36'(2));
        chk("str_p0", logq(0), {ACT_PUSH, 32'hffff0000});
        chk("str_p1", logq(1), {ACT_PUSH, 32'h0000ffff});
        chk("str_gap", 36'(acc_cyc[1] - acc_cyc[0]), 36'(2));

        // Backpressure on tx_full[0]
        act_log.delete();
        tx_full = 4'b0001;
        s_valid = 1'b1;
        s_data  = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("bp_ready", 36'(last_rdy), 36'(0));
        end
        chk("bp_nopush", 36'(act_log.size()), 36'(0));
        tx_full = 4'b0000;
        step();
        chk("bp_accept", 36'(last_rdy), 36'(1));
        s_valid = 1'b0;
        step();
        chk("bp_push", logq(0), {ACT_PUSH, 32'h12345678});

        // Stop with a PUSH in flight and a new sample offered
        act_log.delete();
        send(32'hCAFEF00D, 4);
        stop = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hDEADBEEF;
        step();
        stop = 1'b0;
        s_valid = 1'b0;
        chk("stop_ready", 36'(last_rdy), 36'(0));
        step();
        chk("stop_busy", 36'(busy), 36'(0));
        chk("stop_en", {action, din}, {ACT_EN, 32'h0});
        step();
        chk("stop_cnt", 36'(act_log.size()), 36'(2));
        chk("stop_push", logq(0), {ACT_PUSH, 32'hCAFEF00D});

        // Restart on sm 2; a start while busy is ignored
        do_start(2'd2, 6'd3, 32'h00001234, 24'h000203,
                 32'h5, 32'h80000000, t0);
        sm_sel = 2'd1;
        plen = 6'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_run(20);
        chk("sm2_mindex", 36'(mindex), 36'(2));
        tx_full = 4'b0001;
        send(32'h0BADCAFE, 1);
        tx_full = 4'b0100;
        s_valid = 1'b1;
        s_data = 32'h55AA55AA;
        repeat (3) step();
        chk("sm2_full", 36'(last_rdy), 36'(0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        s_valid = 1'b0;
        tx_full = 4'b0000;
        repeat (3) step();

        // plen=0 goes straight to PEND; stop outside RUN is ignored
        do_start(2'd1, 6'd0, 32'hA0A0A0A0, 24'h123456,
                 32'h0F0F0F0F, 32'h00C00000, t0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        lag = -1;
        for (int i = 0; i < 10 && lag < 0; i++) begin
            if (action !== ACT_NONE) lag = cyc - t0;
            else step();
        end
        chk("p0_first", 36'(action), 36'(ACT_PEND));
        chk("p0_lag", 36'(lag), 36'(2));
        wait_run(20);
        chk("p0_lat", 36'(cyc - t0), 36'(6));
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (3) step();

        // Reset while INSTR 4 is on the port, then a saturated reload
        do_start(2'd0, 6'd10, 32'h1, 24'h2, 32'h3, 32'h4, t0);
        while (cyc < t0 + 7) step();
        chk("rl_instr4", {action, 27'h0, index}, {ACT_INSTR, 32'd4});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rl_none", 36'(action), 36'(ACT_NONE));
        chk("rl_busy", 36'(busy), 36'(0));
        act_log.delete();
        do_start(2'd3, 6'd40, 32'h11, 24'h22, 32'h33, 32'h44, t0);
        wait_run(60);
        chk("sat_lat", 36'(cyc - t0), 36'(39));
        step();
        chk("sat_cnt", 36'(act_log.size()), 36'(37));
        chk("sat_i0", logq(0), {ACT_INSTR, 32'h0000A500});
        chk("sat_i31", logq(31), {ACT_INSTR, 32'h0000A51F});
        chk("sat_pend", logq(32), {ACT_PEND, 32'h00000011});
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
